// File: rtl/chart_sequencer_pkg.sv
// Shared definitions for the chart sequencer and anything that builds
// or inspects beatmap ROM images.
//   state_e      : sequencer FSM states
//   END_MARKER   : ROM word that terminates a chart
//   LANE_*       : bit positions of the four lanes in a note row
//   word_lanes() : lane field of a ROM word (the delay field sits in the
//                  low DELAY_W bits and is sliced by the user)
package chart_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PLAY,
    ST_END
  } state_e;

  localparam logic [15:0] END_MARKER = 16'h0000;

  localparam int unsigned LANE_A = 0;
  localparam int unsigned LANE_S = 1;
  localparam int unsigned LANE_K = 2;
  localparam int unsigned LANE_L = 3;

  localparam int unsigned LANES_MSB = 15;
  localparam int unsigned LANES_LSB = 12;

  function automatic logic [3:0] word_lanes(input logic [15:0] word);
    return word[LANES_MSB:LANES_LSB];
  endfunction

endpackage

// File: rtl/chart_sequencer.sv
// Upstream feeder for game_control. Walks the beatmap ROM of the selected
// song and emits one 4-lane note row per scroll tick.
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low
//   music_id   song select, sampled when start is accepted
//   start      1-cycle pulse, begins a song from IDLE/END
//   pause      level, freezes row emission and countdown
//   tick       1-cycle scroll strobe
//   rom_addr   chart ROM address (song n base = n << (ADDR_W-2))
//   rom_data   {lanes[3:0], delay}, valid 1 clk after rom_addr
//   row_valid  1-cycle pulse, row_notes holds the row for this tick
//   row_notes  bit i = note enters lane i
//   playing    song in progress
//   done       sticky, end marker reached
//   overrun    sticky, tick lost while a fetch was pending
module chart_sequencer
  import chart_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DELAY_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        music_id,
  input  logic              start,
  input  logic              pause,
  input  logic              tick,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              row_valid,
  output logic [3:0]        row_notes,
  output logic              playing,
  output logic              done,
  output logic              overrun
);

  state_e              state_q,   state_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [DELAY_W-1:0]  cnt_q,     cnt_d;
  logic [3:0]          lanes_q,   lanes_d;
  logic [3:0]          notes_q,   notes_d;
  logic                valid_q,   valid_d;
  logic                playing_q, playing_d;
  logic                done_q,    done_d;
  logic                overrun_q, overrun_d;
  logic                pending_q, pending_d;

  logic                tick_ok;
  logic                serve;
  logic [ADDR_W-3:0]   offset_inc;

  assign tick_ok    = tick & ~pause;
  // Offset wraps inside the song region; song select bits are left alone.
  assign offset_inc = addr_q[ADDR_W-3:0] + (ADDR_W-2)'(1);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    lanes_d   = lanes_q;
    notes_d   = notes_q;
    valid_d   = 1'b0;
    playing_d = playing_q;
    done_d    = done_q;
    overrun_d = overrun_q;
    pending_d = pending_q;
    serve     = 1'b0;

    case (state_q)
      ST_IDLE, ST_END: begin
        if (start) begin
          addr_d    = {music_id, {(ADDR_W-2){1'b0}}};
          done_d    = 1'b0;
          overrun_d = 1'b0;
          pending_d = 1'b0;
          playing_d = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      ST_FETCH, ST_WAIT: begin
        if (tick_ok) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
        if (state_q == ST_FETCH) begin
          state_d = ST_WAIT;
        end else if (rom_data == END_MARKER) begin
          state_d   = ST_END;
          playing_d = 1'b0;
          done_d    = 1'b1;
          pending_d = 1'b0;
        end else begin
          lanes_d = word_lanes(rom_data);
          cnt_d   = rom_data[DELAY_W-1:0];
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        serve = ~pause & (tick | pending_q);
        if (serve) begin
          valid_d   = 1'b1;
          // The word's own row goes out on the first served tick; clearing
          // the lane latch makes the following 'delay' ticks empty rows.
          notes_d   = lanes_q;
          lanes_d   = '0;
          // A live tick coinciding with a pending one stays queued.
          pending_d = pending_q & tick;
          if (cnt_q == '0) begin
            addr_d  = {addr_q[ADDR_W-1 -: 2], offset_inc};
            state_d = ST_FETCH;
          end else begin
            cnt_d = cnt_q - DELAY_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      lanes_q   <= '0;
      notes_q   <= '0;
      valid_q   <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      lanes_q   <= lanes_d;
      notes_q   <= notes_d;
      valid_q   <= valid_d;
      playing_q <= playing_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      pending_q <= pending_d;
    end
  end

  assign rom_addr  = addr_q;
  assign row_valid = valid_q;
  assign row_notes = notes_q;
  assign playing   = playing_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_chart_sequencer.sv
// Scoreboard bench for chart_sequencer with a 1-clk-latency ROM model.
module tb_chart_sequencer;
  import chart_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  music_id;
  logic        start, pause, tick;
  logic [11:0] rom_addr;
  logic [15:0] rom_data;
  logic        row_valid;
  logic [3:0]  row_notes;
  logic        playing, done, overrun;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [3:0]  exp_q[$];
  logic [15:0] rom [0:4095];
  logic        prev_valid = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  chart_sequencer #(.ADDR_W(12), .DELAY_W(12)) dut (
    .clk(clk), .rst(rst), .music_id(music_id), .start(start),
    .pause(pause), .tick(tick), .rom_addr(rom_addr), .rom_data(rom_data),
    .row_valid(row_valid), .row_notes(row_notes), .playing(playing),
    .done(done), .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a row.
  always @(negedge clk) begin
    if (row_valid) begin
      check("row_valid_single_clk", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_row", {28'd0, row_notes}, 32'hFFFF_FFFF);
      end else begin
        check("row_notes", {28'd0, row_notes}, {28'd0, exp_q.pop_front()});
      end
    end
    prev_valid <= row_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_tick(input logic [3:0] exp_row, input bit expect_row);
    if (expect_row) exp_q.push_back(exp_row);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_song(input logic [1:0] id);
    music_id = id;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 16'h0000;
    rom[12'h000] = 16'h1002; rom[12'h001] = 16'h8000; rom[12'h002] = 16'h0000;
    rom[12'h800] = 16'h3001; rom[12'h801] = 16'h4000; rom[12'h802] = 16'hC000;
    rom[12'hC00] = 16'h5003; rom[12'hC01] = 16'hA000;
    for (int i = 12'h400; i < 12'h800; i++) rom[i] = 16'h1000;

    rst = 1'b0; music_id = 2'd0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rom_addr", {20'd0, rom_addr}, 32'd0);
    check("rst_row_valid", {31'd0, row_valid}, 32'd0);
    check("rst_row_notes", {28'd0, row_notes}, 32'd0);
    check("rst_playing", {31'd0, playing}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Song 0: row with two empty rows after it, then adjacent row, then end.
    start_song(2'd0);
    check("t1_playing", {31'd0, playing}, 32'd1);
    do_tick(4'b0001, 1);
    do_tick(4'b0000, 1);
    do_tick(4'b0000, 1);
    do_tick(4'b1000, 1);
    do_tick(4'b0000, 0);
    do_tick(4'b0000, 0);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_playing_off", {31'd0, playing}, 32'd0);
    check("t1_rom_addr", {20'd0, rom_addr}, 32'h002);

    // Song 2: music_id changes mid-song, start pulses while busy are ignored.
    start_song(2'd2);
    music_id = 2'd0;
    check("t2_base", {20'd0, rom_addr}, 32'h800);
    do_tick(4'b0011, 1);
    check("t2_addr0", {20'd0, rom_addr}, 32'h800);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t2_start_in_play", {20'd0, rom_addr}, 32'h800);
    exp_q.push_back(4'b0000);
    tick = 1'b1;
    @(negedge clk);
    tick  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("t2_addr1", {20'd0, rom_addr}, 32'h801);
    do_tick(4'b0100, 1);
    check("t2_addr2", {20'd0, rom_addr}, 32'h802);
    do_tick(4'b1100, 1);
    check("t2_addr3", {20'd0, rom_addr}, 32'h803);
    check("t2_done", {31'd0, done}, 32'd1);

    // Song 3: pause mid-countdown.
    start_song(2'd3);
    do_tick(4'b0101, 1);
    do_tick(4'b0000, 1);
    pause = 1'b1;
    do_tick(4'b0000, 0);
    do_tick(4'b0000, 0);
    do_tick(4'b0000, 0);
    check("t3_addr_frozen", {20'd0, rom_addr}, 32'hC00);
    check("t3_notes_hold", {28'd0, row_notes}, 32'd0);
    check("t3_overrun", {31'd0, overrun}, 32'd0);
    pause = 1'b0;
    do_tick(4'b0000, 1);
    check("t3_addr_still", {20'd0, rom_addr}, 32'hC00);
    do_tick(4'b0000, 1);
    check("t3_addr_next", {20'd0, rom_addr}, 32'hC01);
    do_tick(4'b1010, 1);
    check("t3_done", {31'd0, done}, 32'd1);

    // Song 0 rewritten with adjacent rows: pending tick and forced overrun.
    rom[12'h000] = 16'h1000; rom[12'h001] = 16'h2000; rom[12'h002] = 16'h4000;
    rom[12'h003] = 16'h8000; rom[12'h004] = 16'h0000;
    start_song(2'd0);
    check("t4_done_cleared", {31'd0, done}, 32'd0);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    tick = 1'b1;
    repeat (2) @(negedge clk);
    tick = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_pending_no_overrun", {31'd0, overrun}, 32'd0);
    check("t4_pending_served", exp_q.size(), 32'd0);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    tick = 1'b1;
    repeat (3) @(negedge clk);
    tick = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_overrun", {31'd0, overrun}, 32'd1);
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_playing", {31'd0, playing}, 32'd0);

    // Reset mid-song, then replay from base.
    start_song(2'd0);
    check("t5_overrun_cleared", {31'd0, overrun}, 32'd0);
    do_tick(4'b0001, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("t5_rom_addr", {20'd0, rom_addr}, 32'd0);
    check("t5_row_notes", {28'd0, row_notes}, 32'd0);
    check("t5_playing", {31'd0, playing}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    start_song(2'd0);
    check("t5_replay_base", {20'd0, rom_addr}, 32'd0);
    do_tick(4'b0001, 1);
    check("t5_replay_addr", {20'd0, rom_addr}, 32'd1);
    do_tick(4'b0010, 1);
    do_tick(4'b0100, 1);
    do_tick(4'b1000, 1);
    check("t5_done", {31'd0, done}, 32'd1);

    // Song 1: walk the whole region; offset wraps back to the (now cleared) base.
    start_song(2'd1);
    rom[12'h400] = 16'h0000;
    for (int i = 0; i < 1024; i++) begin
      check("t6_in_region", {20'd0, rom_addr}, 32'h400 + i);
      do_tick(4'b0001, 1);
    end
    check("t6_wrapped", {20'd0, rom_addr}, 32'h400);
    check("t6_done", {31'd0, done}, 32'd1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
